// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width and I2S receiver state encoding.
package audio_pkg;

    localparam int unsigned SAMPLE_WIDTH = 24;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } i2s_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// N-stage synchroniser for an asynchronous input, with an optional rising-edge strobe
// taken from one extra flop behind the last synchroniser stage.
module sync_edge_detect #(
    parameter int unsigned Stages     = 2,
    parameter bit          EdgeDetect = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [Stages-1:0] sync_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

    if (EdgeDetect) begin : g_edge
        logic last_q;

        // Delay the synchronised level by one cycle to spot a 0->1 transition.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                last_q <= 1'b0;
            end else begin
                last_q <= sync_q[Stages-1];
            end
        end

        assign rise_o = sync_q[Stages-1] & ~last_q;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S ADC deserialiser: synchronises BCLK/LRCLK/DATA into the system clock domain and
// emits one left/right sample pair per LR period with a single-cycle valid strobe.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SAMPLE_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_codec_bit_clock,
    input  logic                  i_codec_lr_clock,
    input  logic                  i_codec_adc_data,
    output logic [DATA_WIDTH-1:0] o_left_data,
    output logic [DATA_WIDTH-1:0] o_right_data,
    output logic                  o_valid,
    output logic                  o_error
);

    logic bit_edge, bclk_level, lr_s, lr_rise, data_s, data_rise;
    logic unused_sync;

    sync_edge_detect #(.Stages(SYNC_STAGES), .EdgeDetect(1'b1)) u_sync_bclk (
        .clk_i  (i_clock),
        .rst_i  (i_reset),
        .d_i    (i_codec_bit_clock),
        .q_o    (bclk_level),
        .rise_o (bit_edge)
    );

    sync_edge_detect #(.Stages(SYNC_STAGES), .EdgeDetect(1'b0)) u_sync_lr (
        .clk_i  (i_clock),
        .rst_i  (i_reset),
        .d_i    (i_codec_lr_clock),
        .q_o    (lr_s),
        .rise_o (lr_rise)
    );

    sync_edge_detect #(.Stages(SYNC_STAGES), .EdgeDetect(1'b0)) u_sync_data (
        .clk_i  (i_clock),
        .rst_i  (i_reset),
        .d_i    (i_codec_adc_data),
        .q_o    (data_s),
        .rise_o (data_rise)
    );

    assign unused_sync = ^{bclk_level, lr_rise, data_rise};

    i2s_state_t            state_q, state_d;
    logic                  lr_prev_q, lr_prev_d;
    logic                  left_ok_q, left_ok_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  valid_q, valid_d, error_q, error_d;
    logic                  word_ok;

    // Per-bit datapath candidates: saturating counter and capped shift-in.
    always_comb begin
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        shift_in = (32'(cnt_q) < DATA_WIDTH) ? {shift_q[DATA_WIDTH-2:0], data_s} : shift_q;
        word_ok  = (32'(cnt_inc) >= DATA_WIDTH);
    end

    // Framing FSM: acts only on BCLK rising edges; closes a slot on each LR change.
    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        left_ok_d = left_ok_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        if (bit_edge) begin
            lr_prev_d = lr_s;
            case (state_q)
                WAIT_SYNC: begin
                    // Lock on at a right-to-left boundary; the next bit is a left MSB.
                    if (lr_prev_q && !lr_s) begin
                        state_d = LEFT;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                LEFT, RIGHT: begin
                    shift_d = shift_in;
                    cnt_d   = cnt_inc;
                    if (lr_s != lr_prev_q) begin
                        // The bit on the LR-change edge is the LSB of the slot being closed.
                        error_d = !word_ok;
                        if (state_q == LEFT) begin
                            if (word_ok) begin
                                hold_d    = shift_in;
                                left_ok_d = 1'b1;
                            end
                            state_d = RIGHT;
                        end else begin
                            if (word_ok && left_ok_q) begin
                                left_d  = hold_q;
                                right_d = shift_in;
                                valid_d = 1'b1;
                            end
                            left_ok_d = 1'b0;
                            state_d   = LEFT;
                        end
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= WAIT_SYNC;
            lr_prev_q <= 1'b0;
            left_ok_q <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            left_ok_q <= left_ok_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign o_left_data  = left_q;
    assign o_right_data = right_q;
    assign o_valid      = valid_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed self-checking bench for i2s_receiver: framing, padding, short slots,
// resets mid-stream and output latency.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        adc = 1'b0;
    logic [23:0] left_data, right_data;
    logic        valid, err;

    int total = 0;
    int bad = 0;
    int valid_total = 0;
    int err_total = 0;
    int both_total = 0;
    logic [23:0] last_l = '0;
    logic [23:0] last_r = '0;

    always #5 clk = ~clk;

    i2s_receiver dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_codec_bit_clock (bclk),
        .i_codec_lr_clock  (lrclk),
        .i_codec_adc_data  (adc),
        .o_left_data       (left_data),
        .o_right_data      (right_data),
        .o_valid           (valid),
        .o_error           (err)
    );

    // Count strobes and capture the data presented with each valid pulse.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_total <= valid_total + 1;
            last_l      <= left_data;
            last_r      <= right_data;
        end
        if (err === 1'b1) err_total <= err_total + 1;
        if (valid === 1'b1 && err === 1'b1) both_total <= both_total + 1;
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One BCLK period (320 time units): LR/DATA change while BCLK is low.
    task automatic send_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        adc   = d;
        #160;
        bclk  = 1'b1;
        #160;
    endtask

    // The last bit of a slot already carries the next slot's LR value (I2S delay).
    task automatic send_slot(input logic lr_this, input logic lr_next, input logic [31:0] word,
                             input int nbits, input int slot_len);
        for (int j = 0; j < slot_len; j++) begin
            send_bit((j == slot_len - 1) ? lr_next : lr_this,
                     (j < nbits) ? word[nbits-1-j] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int slot_len);
        send_slot(1'b0, 1'b1, {8'h00, l}, 24, slot_len);
        send_slot(1'b1, 1'b0, {8'h00, r}, 24, slot_len);
    endtask

    // A few right-slot bits ending in a 1->0 LR change to lock the receiver.
    task automatic preamble();
        send_slot(1'b1, 1'b0, 32'h0, 0, 4);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pulse_reset();
        #1;
        total++; if (left_data !== 24'h0) begin bad++; $display("FAIL reset_left: got %h expected %h", left_data, 24'h0); end
        total++; if (right_data !== 24'h0) begin bad++; $display("FAIL reset_right: got %h expected %h", right_data, 24'h0); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_error: got %b expected 0", err); end
    endtask

    task automatic test_basic();
        int v0, e0;
        pulse_reset();
        v0 = valid_total; e0 = err_total;
        preamble();
        send_frame(24'h123456, 24'hABCDEF, 32);
        send_frame(24'h123456, 24'hABCDEF, 32);
        settle();
        total++; if (valid_total - v0 !== 2) begin bad++; $display("FAIL basic_valid_count: got %0d expected 2", valid_total - v0); end
        total++; if (err_total - e0 !== 0) begin bad++; $display("FAIL basic_error_count: got %0d expected 0", err_total - e0); end
        total++; if (last_l !== 24'h123456) begin bad++; $display("FAIL basic_left: got %h expected %h", last_l, 24'h123456); end
        total++; if (last_r !== 24'hABCDEF) begin bad++; $display("FAIL basic_right: got %h expected %h", last_r, 24'hABCDEF); end
    endtask

    task automatic test_mid_slot_start();
        int v0;
        pulse_reset();
        v0 = valid_total;
        send_slot(1'b0, 1'b0, 32'h15, 5, 5);
        send_slot(1'b1, 1'b0, 32'h2A5, 10, 10);
        send_frame(24'h800000, 24'h7FFFFF, 32);
        settle();
        total++; if (valid_total - v0 !== 1) begin bad++; $display("FAIL midstart_valid_count: got %0d expected 1", valid_total - v0); end
        total++; if (last_l !== 24'h800000) begin bad++; $display("FAIL midstart_left: got %h expected %h", last_l, 24'h800000); end
        total++; if (last_r !== 24'h7FFFFF) begin bad++; $display("FAIL midstart_right: got %h expected %h", last_r, 24'h7FFFFF); end
    endtask

    task automatic test_24bit_slots();
        int v0;
        pulse_reset();
        v0 = valid_total;
        preamble();
        send_frame(24'hFFFFFF, 24'h000001, 24);
        settle();
        total++; if (valid_total - v0 !== 1) begin bad++; $display("FAIL slot24_valid_count: got %0d expected 1", valid_total - v0); end
        total++; if (last_l !== 24'hFFFFFF) begin bad++; $display("FAIL slot24_left: got %h expected %h", last_l, 24'hFFFFFF); end
        total++; if (last_r !== 24'h000001) begin bad++; $display("FAIL slot24_right: got %h expected %h", last_r, 24'h000001); end
    endtask

    task automatic test_short_right();
        int v0, e0;
        pulse_reset();
        v0 = valid_total; e0 = err_total;
        preamble();
        send_slot(1'b0, 1'b1, 32'h111111, 24, 32);
        send_slot(1'b1, 1'b0, 32'hBEEF, 16, 16);
        settle();
        total++; if (err_total - e0 !== 1) begin bad++; $display("FAIL short_error_count: got %0d expected 1", err_total - e0); end
        total++; if (valid_total - v0 !== 0) begin bad++; $display("FAIL short_valid_count: got %0d expected 0", valid_total - v0); end
        total++; if (left_data !== 24'h0) begin bad++; $display("FAIL short_left_held: got %h expected %h", left_data, 24'h0); end
        @(negedge clk);
        send_frame(24'h654321, 24'h0FEDCB, 32);
        settle();
        total++; if (valid_total - v0 !== 1) begin bad++; $display("FAIL recover_valid_count: got %0d expected 1", valid_total - v0); end
        total++; if (err_total - e0 !== 1) begin bad++; $display("FAIL recover_error_count: got %0d expected 1", err_total - e0); end
        total++; if (last_l !== 24'h654321) begin bad++; $display("FAIL recover_left: got %h expected %h", last_l, 24'h654321); end
        total++; if (last_r !== 24'h0FEDCB) begin bad++; $display("FAIL recover_right: got %h expected %h", last_r, 24'h0FEDCB); end
    endtask

    task automatic test_reset_mid_left();
        int v0;
        logic [31:0] w;
        pulse_reset();
        v0 = valid_total;
        preamble();
        send_frame(24'hA5A5A5, 24'h5A5A5A, 32);
        settle();
        total++; if (valid_total - v0 !== 1) begin bad++; $display("FAIL prereset_valid_count: got %0d expected 1", valid_total - v0); end
        total++; if (right_data !== 24'h5A5A5A) begin bad++; $display("FAIL prereset_right: got %h expected %h", right_data, 24'h5A5A5A); end
        @(negedge clk);
        w = 32'h3C3C3C00;
        for (int j = 0; j < 10; j++) send_bit(1'b0, w[31-j]);
        pulse_reset();
        #1;
        total++; if (left_data !== 24'h0) begin bad++; $display("FAIL midreset_left: got %h expected %h", left_data, 24'h0); end
        total++; if (right_data !== 24'h0) begin bad++; $display("FAIL midreset_right: got %h expected %h", right_data, 24'h0); end
        @(negedge clk);
        v0 = valid_total;
        for (int j = 10; j < 32; j++) send_bit((j == 31) ? 1'b1 : 1'b0, w[31-j]);
        send_slot(1'b1, 1'b0, 32'h0F0F0F, 24, 32);
        settle();
        total++; if (valid_total - v0 !== 0) begin bad++; $display("FAIL postreset_no_valid: got %0d expected 0", valid_total - v0); end
        @(negedge clk);
        send_frame(24'h13579B, 24'h2468AC, 32);
        settle();
        total++; if (valid_total - v0 !== 1) begin bad++; $display("FAIL postreset_valid_count: got %0d expected 1", valid_total - v0); end
        total++; if (last_l !== 24'h13579B) begin bad++; $display("FAIL postreset_left: got %h expected %h", last_l, 24'h13579B); end
        total++; if (last_r !== 24'h2468AC) begin bad++; $display("FAIL postreset_right: got %h expected %h", last_r, 24'h2468AC); end
    endtask

    task automatic test_latency();
        logic [23:0] r;
        r = 24'hC0FFEE;
        pulse_reset();
        preamble();
        send_slot(1'b0, 1'b1, 32'h00BEAD, 24, 24);
        for (int j = 0; j < 23; j++) send_bit(1'b1, r[23-j]);
        bclk  = 1'b0;
        lrclk = 1'b0;
        adc   = r[0];
        #160;
        @(negedge clk);
        bclk = 1'b1;
        // Edge N: the first posedge that registers BCLK high.
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_n: got %b expected 0", valid); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_n1: got %b expected 0", valid); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL latency_n2: got %b expected 1", valid); end
        total++; if (left_data !== 24'h00BEAD) begin bad++; $display("FAIL latency_left: got %h expected %h", left_data, 24'h00BEAD); end
        total++; if (right_data !== 24'hC0FFEE) begin bad++; $display("FAIL latency_right: got %h expected %h", right_data, 24'hC0FFEE); end
        @(posedge clk); #1;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL latency_pulse_width: got %b expected 0", valid); end
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_slot_start();
        test_24bit_slots();
        test_short_right();
        test_reset_mid_left();
        test_latency();
        total++; if (both_total !== 0) begin bad++; $display("FAIL valid_error_overlap: got %0d expected 0", both_total); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
